icache_dm: RTL and testbench

- Direct-mapped, read-only instruction cache between the PC register and the IF/ID pipeline register.
- Replaces the flat instruction memory in the IF stage.
- Hits return the instruction combinationally in the same cycle.
- Misses assert stall to the PC and IF/ID write enables, then refill a whole line from a slower backing memory over a word-serial req/ack handshake.

---
 rtl/icache_dm.sv | 153 +++++++++++++++
 tb/tb_icache_dm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache between the PC and the IF/ID register.
// Latency: hits return inst combinationally in the same cycle; a miss stalls for
//          1 + 1 + WORDS ack beats + 1 cycles minimum (7 with WORDS=4, zero-wait memory).
// Backpressure: stall holds PC and IF/ID; refill waits on mem_ack once per word, with req/addr held.
module icache_dm #(
    parameter int          LINES    = 16,
    parameter int          WORDS    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // Address split: | tag | index | word offset | byte (ignored) |
    localparam int OFF  = $clog2(WORDS);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - OFF - IDX;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS - 1);

    logic [OFF-1:0]  pc_off;
    logic [IDX-1:0]  pc_idx;
    logic [TAGW-1:0] pc_tag;
    logic            unused_byte_bits;

    logic [1:0]      state;
    logic [TAGW-1:0] refill_tag;
    logic [IDX-1:0]  refill_index;
    logic [OFF-1:0]  beat;
    logic            drop;

    // Storage: tags and data carry no reset; only the valid bits do.
    logic [TAGW-1:0] tag_mem  [LINES];
    logic [31:0]     data_mem [LINES*WORDS];
    logic [LINES-1:0] valid;

    logic hit;
    logic ack_fire;
    logic last_beat;

    assign pc_off           = pc_addr[OFF+1:2];
    assign pc_idx           = pc_addr[OFF+IDX+1:OFF+2];
    assign pc_tag           = pc_addr[31:OFF+IDX+2];
    assign unused_byte_bits = ^pc_addr[1:0];

    assign ack_fire  = (state == ST_REFILL) && mem_ack;
    assign last_beat = (beat == LAST_BEAT);

    // Lookup: only IDLE can hit; a flush in the same cycle forces a miss.
    // Reset is folded in so the outputs are NOP/stall while reset is held.
    always_comb begin
        hit = 1'b0;
        if (reset && (state == ST_IDLE) && !flush && valid[pc_idx] &&
            (tag_mem[pc_idx] == pc_tag)) begin
            hit = 1'b1;
        end
    end

    // Output mux: hit data, otherwise a NOP bubble with stall asserted.
    always_comb begin
        inst  = NOP_INST;
        stall = 1'b1;
        if (hit) begin
            inst  = data_mem[{pc_idx, pc_off}];
            stall = 1'b0;
        end
    end

    // Backing-memory request is a direct view of the refill registers, so it is
    // stable for the whole beat and drops asynchronously with reset.
    assign mem_req  = (state == ST_REFILL);
    assign mem_addr = {refill_tag, refill_index, beat, 2'b00};

    // Refill sequencer: IDLE -> REFILL (WORDS ack beats) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            refill_tag   <= '0;
            refill_index <= '0;
            beat         <= '0;
            drop         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A flushed lookup does not start a refill; it retries next cycle.
                    if (!hit && !flush) begin
                        state        <= ST_REFILL;
                        refill_tag   <= pc_tag;
                        refill_index <= pc_idx;
                        beat         <= '0;
                        drop         <= 1'b0;
                    end
                end
                ST_REFILL: begin
                    // A flush mid-refill lets the handshake finish but poisons the line.
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Valid bits: flush clears all; the final beat validates the line unless a
    // flush was seen at any point during this refill (including this cycle).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            if (flush) begin
                valid <= '0;
            end
            if (ack_fire && last_beat) begin
                valid[refill_index] <= !(drop || flush);
            end
        end
    end

    // Data and tag arrays: one word per ack, tag written with the last word.
    always_ff @(posedge clk) begin
        if (ack_fire) begin
            data_mem[{refill_index, beat}] <= mem_rdata;
            if (last_beat) begin
                tag_mem[refill_index] <= refill_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: reset, fills, hits, conflict eviction, flush,
// redirect during refill, mid-refill reset and a random-wait-state sweep.
// Backing memory is a behavioural model answering the req/ack handshake.
module tb_icache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_addr;
    logic        flush;
    logic [31:0] inst;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] acked[$];
    bit          rand_wait = 1'b0;
    bit          hs_chk    = 1'b0;

    int          mcnt  = -1;
    logic        prv_req = 1'b0;
    logic        prv_ack = 1'b0;
    logic [31:0] prv_addr = 32'd0;

    int n;

    always #5 clk = ~clk;

    icache_dm #(
        .LINES    (16),
        .WORDS    (4),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_addr   (pc_addr),
        .flush     (flush),
        .inst      (inst),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Backing-memory contents: words 0..3 are 0x11,0x22,0x33,0x44; elsewhere addr ^ 0xDEAD0000.
    function automatic logic [31:0] model(input logic [31:0] a);
        logic [31:0] w;
        w = {30'd0, a[3:2]};
        if (a < 32'h10) return (w + 32'd1) * 32'h11;
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Fetch at a: wait (bounded) for stall=0, then compare inst. n = stalled cycles.
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, output int cyc);
        cyc = 0;
        pc_addr = a;
        @(negedge clk);
        while (stall && cyc < 300) begin
            cyc++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        check("fetch_stall", 32'(stall), 32'd0);
        check("fetch_inst", inst, exp);
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Memory model: first ack one cycle after req rises (plus optional waits),
    // then one ack per beat after 0 (or 0..5 random) wait cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (hs_chk && prv_req && !prv_ack) begin
                check("req_hold", 32'(mem_req), 32'd1);
                check("addr_stable", mem_addr, prv_addr);
            end
            prv_req  = mem_req;
            prv_addr = mem_addr;
            if (!mem_req) begin
                mem_ack = 1'b0;
                mcnt    = -1;
            end else begin
                if (mcnt < 0) mcnt = 1 + (rand_wait ? int'($urandom_range(0, 5)) : 0);
                if (mcnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = model(mem_addr);
                    acked.push_back(mem_addr);
                    mcnt = rand_wait ? int'($urandom_range(0, 5)) : 0;
                end else begin
                    mem_ack = 1'b0;
                    mcnt--;
                end
            end
            prv_ack = mem_ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        pc_addr = 32'd0;
        flush   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Cold miss on line 0: 7 stall cycles, ascending word requests.
        fetch(32'h0, 32'h11, n);
        check("miss0_cycles", 32'(n), 32'd7);
        check("miss0_beats", 32'(acked.size()), 32'd4);
        for (int i = 0; i < acked.size() && i < 4; i++) check("miss0_addr", acked[i], 32'(i * 4));

        // Sweep the rest of the line: all hits, no memory traffic.
        fetch(32'h4, 32'h22, n); check("hit4_cycles", 32'(n), 32'd0);
        fetch(32'h8, 32'h33, n); check("hit8_cycles", 32'(n), 32'd0);
        fetch(32'hC, 32'h44, n); check("hitC_cycles", 32'(n), 32'd0);
        check("hit_no_req", 32'(mem_req), 32'd0);

        // Conflict: tag 1 evicts tag 0 at index 0, then 0x0 misses again.
        acked.delete();
        fetch(32'h100, 32'hDEAD_0100, n); check("t1_cycles", 32'(n), 32'd7);
        check("t1_first_addr", acked[0], 32'h100);
        fetch(32'h10C, 32'hDEAD_010C, n); check("t1_hit_cycles", 32'(n), 32'd0);
        fetch(32'h0, 32'h11, n); check("evict_cycles", 32'(n), 32'd7);

        // Flush during beat 2 of a refill to 0x40: handshake completes, line stays invalid.
        acked.delete();
        pc_addr = 32'h40;
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 100 && mem_req; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        check("flush_req_drop", 32'(mem_req), 32'd0);
        step();
        check("flush_beats", 32'(acked.size()), 32'd4);
        fetch(32'h40, 32'hDEAD_0040, n);
        check("flush_refill_cycles", 32'(n), 32'd7);
        check("flush_refill_beats", 32'(acked.size()), 32'd8);

        // Flush in IDLE on a hitting address: forced miss, no refill start that cycle.
        pc_addr = 32'h40;
        flush   = 1'b1;
        @(negedge clk);
        check("flush_idle_stall", 32'(stall), 32'd1);
        check("flush_idle_inst", inst, 32'h0000_0013);
        step();
        flush = 1'b0;
        check("flush_idle_no_req", 32'(mem_req), 32'd0);
        fetch(32'h40, 32'hDEAD_0040, n);
        check("flush_idle_refetch", 32'(n), 32'd7);

        // Redirect during refill: the latched 0x300 refill finishes, then 0x10 is fetched.
        acked.delete();
        pc_addr = 32'h300;
        repeat (2) step();
        fetch(32'h10, 32'hDEAD_0010, n);
        check("redir_beats", 32'(acked.size()), 32'd8);
        check("redir_addr0", acked[0], 32'h300);
        check("redir_addr3", acked[3], 32'h30C);
        check("redir_addr4", acked[4], 32'h10);
        fetch(32'h304, 32'hDEAD_0304, n);
        check("redir_line_hit", 32'(n), 32'd0);

        // Asynchronous reset mid-refill.
        pc_addr = 32'h80;
        step();
        check("mid_req_pre", 32'(mem_req), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd1);
        check("mid_rst_inst", inst, 32'h0000_0013);
        step();
        reset   = 1'b1;
        pc_addr = 32'h0;
        fetch(32'h0, 32'h11, n);
        check("post_rst_miss", 32'(n), 32'd7);

        // Random PCs with random memory wait states and handshake stability checks.
        rand_wait = 1'b1;
        hs_chk    = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a;
            a = $urandom & 32'h0000_07FC;
            fetch(a, model(a), n);
        end
        hs_chk = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
